// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS debug responder: host opcodes and FSM states.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    OP_MEM_WR   = 2'b00,
    OP_REG_RD   = 2'b01,
    OP_RUN      = 2'b10,
    OP_HALT_REQ = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEMWR    = 3'd1,
    S_REGRD    = 3'd2,
    S_RUN      = 3'd3,
    S_HALTWAIT = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  // Width of the halt-wait cycle counter.
  localparam int CNT_W = 8;

  // Work state entered when a command with this opcode is accepted.
  function automatic state_e op_to_state(input op_e op);
    case (op)
      OP_MEM_WR: return S_MEMWR;
      OP_REG_RD: return S_REGRD;
      OP_RUN:    return S_RUN;
      default:   return S_HALTWAIT;
    endcase
  endfunction

endpackage

// File: rtl/mips_dbg_responder.sv
// Host debug command responder for a MIPS core: writes program memory, reads
// the register file, starts the core at a PC and requests a halt. Each command
// produces exactly one response held until the host consumes it.
module mips_dbg_responder
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              core_hold,
  input  logic              core_halted,
  output logic              core_pc_load,
  output logic [31:0]       core_pc
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state, state_n;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;
  logic              ok_r;      // command legal in the core state seen at accept
  logic              hold_r;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rsp_data_r;
  logic              rsp_err_r;

  op_e op;
  assign op = op_e'(cmd_op);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  // NOTE: state_n is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (cmd_valid) state_n = op_to_state(op);
      S_MEMWR,
      S_REGRD,
      S_RUN:      state_n = S_RESP;
      S_HALTWAIT: if (core_halted || cnt == TO_LAST) state_n = S_RESP;
      S_RESP:     if (rsp_ready) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Command latch, core-hold control, halt-wait counter and response capture.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      data_r     <= '0;
      ok_r       <= 1'b0;
      hold_r     <= 1'b1;
      cnt        <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          addr_r     <= cmd_addr;
          data_r     <= cmd_data;
          cnt        <= '0;
          rsp_data_r <= '0;
          rsp_err_r  <= 1'b0;
          case (op)
            OP_MEM_WR: ok_r <= hold_r;
            OP_REG_RD: ok_r <= ((cmd_addr >> 5) == '0);
            OP_RUN: begin
              ok_r <= hold_r;
              if (hold_r) hold_r <= 1'b0;
            end
            default: begin
              ok_r   <= 1'b1;
              hold_r <= 1'b1;
            end
          endcase
        end
        S_MEMWR, S_RUN: rsp_err_r <= !ok_r;
        S_REGRD: begin
          rsp_data_r <= ok_r ? reg_rdata : 32'd0;
          rsp_err_r  <= !ok_r;
        end
        S_HALTWAIT: if (!core_halted) begin
          if (cnt == TO_LAST) rsp_err_r <= 1'b1;
          else                cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the latched command; strobes only exist
  // for the single work cycle of a legal command.
  assign cmd_ready    = rst_n && (state == S_IDLE);
  assign rsp_valid    = (state == S_RESP);
  assign rsp_data     = rsp_data_r;
  assign rsp_err      = rsp_err_r;
  assign mem_we       = (state == S_MEMWR) && ok_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = data_r;
  assign reg_raddr    = addr_r[4:0];
  assign core_pc_load = (state == S_RUN) && ok_r;
  assign core_pc      = data_r;
  assign core_hold    = hold_r;

endmodule

// File: doc/mips_dbg_responder.md
MIPS_DBG_RESPONDER -- requirements
Module: mips_dbg_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction/data memory word-address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles HALT_REQ waits for the core to halt.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk1  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  host command present.
REQ-007 cmd_ready  out  1  responder accepts a command this cycle.
REQ-008 cmd_op  in  2  opcode: 00 MEM_WR, 01 REG_RD, 10 RUN, 11 HALT_REQ.
REQ-009 cmd_addr  in  ADDR_W  memory word address, or register index in bits [4:0].
REQ-010 cmd_data  in  32  write data for MEM_WR; start PC for RUN.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  host consumes the response.
REQ-013 rsp_data  out  32  read data; 0 for non-read ops.
REQ-014 rsp_err  out  1  command rejected or timed out.
REQ-015 mem_we  out  1  one-cycle memory write strobe.
REQ-016 mem_addr  out  ADDR_W  memory write address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 reg_raddr  out  5  register-file read index.
REQ-019 reg_rdata  in  32  register-file read data, combinational from reg_raddr.
REQ-020 core_hold  out  1  holds the pipeline halted while high.
REQ-021 core_halted  in  1  core HALTED flag.
REQ-022 core_pc_load  out  1  one-cycle pulse loading core_pc and clearing TAKEN_BRANCH.
REQ-023 core_pc  out  32  PC value to load.

Function
REQ-024 FSM states SHALL be IDLE, MEMWR, REGRD, RUN, HALTWAIT, RESP.
REQ-025 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-026 Accept SHALL latch op/addr/data and move to the state for cmd_op.
REQ-027 MEM_WR accepted at cycle N with core_hold=1 SHALL pulse mem_we at N+1 (latched addr/data), then RESP with rsp_valid at N+2, rsp_err=0.
REQ-028 MEM_WR with core_hold=0 SHALL perform no write and respond at N+2 with rsp_err=1.
REQ-029 REG_RD SHALL drive reg_raddr=cmd_addr[4:0] at N+1, capture reg_rdata at the end of N+1, and present it on rsp_data at N+2.
REQ-030 REG_RD with cmd_addr[ADDR_W-1:5] nonzero SHALL respond at N+2 with rsp_err=1, rsp_data=0.
REQ-031 RUN SHALL pulse core_pc_load with core_pc=cmd_data at N+1, drop core_hold at N+1, and respond at N+2.
REQ-032 RUN while core_hold=0 SHALL respond rsp_err=1 with no pc_load.
REQ-033 HALT_REQ SHALL raise core_hold at N+1 and enter HALTWAIT with an 8-bit counter cleared.
REQ-034 HALTWAIT SHALL go to RESP (rsp_err=0) the first cycle core_halted=1, else after TIMEOUT cycles with rsp_err=1; core_hold stays 1 either way.
REQ-035 RESP SHALL hold rsp_valid, rsp_data, rsp_err stable until rsp_ready, then return to IDLE the following cycle.
REQ-036 rsp_valid and rsp_ready both high SHALL complete the response even if cmd_valid is also high; no command is accepted that cycle.
REQ-037 mem_we and core_pc_load SHALL never be high more than one cycle per command.
REQ-038 core_halted=1 already at HALT_REQ accept SHALL give rsp_valid at N+2.

Reset
REQ-039 rst_n low SHALL immediately force: state IDLE, cmd_ready=0 during reset then 1 after, rsp_valid=0, rsp_data=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_raddr=0, core_pc_load=0, core_pc=0, core_hold=1.
REQ-040 Reset mid-command SHALL abort it without issuing mem_we or core_pc_load and without a response.

Structure
REQ-041 Opcode encodings and FSM state encodings SHALL live in a shared package mips_dbg_pkg.
REQ-042 Implementation SHALL be a single module; no sub-module.

Verification
REQ-043 After reset, MEM_WR addr 0 data 32'h2801000a -> mem_we one cycle at N+1 with mem_addr=0, rsp_valid at N+2, rsp_err=0.
REQ-044 RUN data 0 after loading program -> core_pc_load pulse with core_pc=0, core_hold falls; subsequent MEM_WR -> rsp_err=1, no mem_we.
REQ-045 HALT_REQ with core_halted rising 5 cycles later -> rsp_err=0; with core_halted stuck 0 -> rsp_err=1 after 255 cycles.
REQ-046 REG_RD addr 5 with reg_rdata=30 -> rsp_data=30 at N+2; REG_RD addr 32 -> rsp_err=1, rsp_data=0.
REQ-047 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready low throughout.
REQ-048 rst_n asserted the cycle after MEM_WR accept -> no mem_we, rsp_valid=0, core_hold=1.
